hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Producer side of the operand-bypass path: tracks destination registers of long-latency ops (loads, multi-cycle ALU) issued but not yet written back.
- Generates the `stall` that freezes decode and the bypass buffer while a source or destination operand is still pending.
- Sits beside decode; retires entries from the writeback completion port.
- Results completing in cycle N are readable via the bypass buffer from cycle N+1.

Parameters:
- MAX_OUTSTANDING, 4, maximum simultaneously pending long-latency ops (1..31).
- CNT_W, 3, width of the outstanding counter; must hold MAX_OUTSTANDING.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous active-high reset.
- issue_valid  input  1  decode presents an instruction.
- issue_rs1  input  5  source register 1.
- issue_use_rs1  input  1  instruction reads rs1.
- issue_rs2  input  5  source register 2.
- issue_use_rs2  input  1  instruction reads rs2.
- issue_rd  input  5  destination register.
- issue_long  input  1  instruction is long-latency and writes rd via the completion port.
- issue_kill  input  1  branch flush; current issue is discarded.
- complete_valid  input  1  long-latency result written back this cycle.
- complete_rd  input  5  register being written back.
- stall  output  1  decode must hold; combinational.
- pending  output  32  registered pending mask; bit 0 always 0.
- outstanding  output  CNT_W  number of pending entries.
- full  output  1  outstanding == MAX_OUTSTANDING.
- err_spurious  output  1  sticky: completion for a non-pending register.
- stall_cycles  output  32  saturating count of cycles with stall=1.

Behaviour:
- Reset:
  - pending = 0, outstanding = 0, err_spurious = 0, stall_cycles = 0.
  - full = 0 (outputs derived from registered state are 0 during reset).
  - stall is forced 0 while reset is high.
- raw_hit = issue_use_rs1 & pending[issue_rs1], or issue_use_rs2 & pending[issue_rs2]. Uses the registered mask only; a same-cycle completion does NOT clear the hazard.
- waw_hit = issue_long & pending[issue_rd] & (issue_rd != 0).
- cap_hit = issue_long & full.
- stall = issue_valid & ~issue_kill & (raw_hit | waw_hit | cap_hit).
- accept = issue_valid & ~issue_kill & ~stall.
- Next-state update, registered on posedge clk:
  - set_vec: bit issue_rd if accept & issue_long & issue_rd != 0.
  - clr_vec: bit complete_rd if complete_valid & pending[complete_rd].
  - pending <= (pending & ~clr_vec) | set_vec.
  - outstanding <= outstanding + |set_vec - |clr_vec (simultaneous set and clear leaves it unchanged).
- x0:
  - A long op to rd=0 is accepted without setting any bit or changing the count.
  - A completion to rd=0 is ignored and is not an error.
- Spurious completion: complete_valid with complete_rd != 0 and pending[complete_rd] = 0 sets err_spurious (cleared only by reset); no state change.
- Set and clear of the same rd in one cycle cannot occur, because waw_hit stalls the issue. The bench asserts this never happens.
- issue_kill:
  - Discards only the presented instruction; stall = 0 that cycle.
  - Already-pending ops still complete and clear normally; memory requests are not cancelled.
- stall_cycles increments each cycle stall = 1 and saturates at 0xFFFFFFFF.
- Latency:
  - stall is 0-cycle from the issue inputs.
  - A completion in cycle N removes the hazard from cycle N+1.
  - Minimum load-to-use distance is therefore completion latency + 1.
- Reset mid-operation clears all state. Late completions after reset flag err_spurious; this is the intended diagnostic.

Decomposition:
- Shared pipeline package:
  - REG_ADDR_W = 5
  - NUM_REGS = 32
  - XLEN = 32
  - MAX_OUTSTANDING default
- Sub-module sat_counter (width param, inc, reset) used for stall_cycles; reusable for the other performance counters.

Test Plan:
- Load-use: issue long rd=5 cycle 0, next cycle issue rs1=5 use_rs1=1 → stall=1 until complete_rd=5 in cycle 4; stall=0 in cycle 5, accepted; stall_cycles=4.
- Same-cycle completion: pending[7]=1; in one cycle complete_rd=7 and issue rs2=7 → stall=1 that cycle, 0 next; outstanding 1→0.
- Capacity: with MAX=4, issue long rd=1,2,3,4 → full=1; long rd=6 stalls; complete rd=2 → rd=6 accepted next cycle, outstanding=4, pending=0x5A.
- x0 / WAW: long rd=0 accepted with pending unchanged; long rd=9 twice back-to-back → second stalls until complete_rd=9.
- Kill and spurious: hazardous issue with issue_kill=1 → stall=0, no state change; complete_rd=12 while not pending → err_spurious=1 and stays 1.
- Reset mid-op: pending=0x0000_0006, reset one cycle → pending=0, outstanding=0, stall=0; subsequent complete_rd=1 → err_spurious=1.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline constants and register-mask helpers for the decode/bypass path.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package hazard_scoreboard_pkg;

   localparam int REG_ADDR_W          = 5;
   localparam int NUM_REGS            = 32;
   localparam int XLEN                = 32;
   localparam int MAX_OUTSTANDING_DEF = 4;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [NUM_REGS-1:0]   reg_mask_t;

   // One-hot mask selecting a single architectural register.
   function automatic reg_mask_t reg_onehot(input reg_addr_t addr);
      reg_mask_t m;
      m       = '0;
      m[addr] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/hazard_scoreboard_sat_counter.sv
// Saturating event counter, used for performance counters such as stall cycles.
// Latency: count reflects an inc one cycle after it is presented.
// Backpressure: none; holds at all-ones once saturated.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Next count: increment unless already saturated.
   always_comb begin
      count_d = count_q;
      if (inc && (count_q != '1)) begin
         count_d = count_q + W'(1);
      end
      if (reset) begin
         count_d = '0;
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks destination registers of issued long-latency ops and stalls decode on RAW/WAW/capacity hazards.
// Latency: stall is combinational from issue inputs; a completion clears its hazard the next cycle.
// Backpressure: stall holds decode; killed issues never stall; completions are always accepted.
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
   parameter int CNT_W           = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             issue_valid,
   input  logic [4:0]       issue_rs1,
   input  logic             issue_use_rs1,
   input  logic [4:0]       issue_rs2,
   input  logic             issue_use_rs2,
   input  logic [4:0]       issue_rd,
   input  logic             issue_long,
   input  logic             issue_kill,
   input  logic             complete_valid,
   input  logic [4:0]       complete_rd,
   output logic             stall,
   output logic [31:0]      pending,
   output logic [CNT_W-1:0] outstanding,
   output logic             full,
   output logic             err_spurious,
   output logic [31:0]      stall_cycles
);

   reg_mask_t        pending_q, pending_d;
   logic [CNT_W-1:0] outstanding_q, outstanding_d;
   logic             err_spurious_q, err_spurious_d;

   logic      full_int;
   logic      raw_hit, waw_hit, cap_hit;
   logic      stall_int, accept;
   logic      set_any, clr_any, spurious;
   reg_mask_t set_vec, clr_vec;

   assign full_int = (outstanding_q == CNT_W'(MAX_OUTSTANDING));

   // Hazard detection against the registered mask only; a same-cycle completion
   // is not forwarded, since the bypass buffer only holds it from the next cycle.
   always_comb begin
      raw_hit   = (issue_use_rs1 & pending_q[issue_rs1]) |
                  (issue_use_rs2 & pending_q[issue_rs2]);
      waw_hit   = issue_long & pending_q[issue_rd] & (issue_rd != '0);
      cap_hit   = issue_long & full_int;
      stall_int = ~reset & issue_valid & ~issue_kill & (raw_hit | waw_hit | cap_hit);
      accept    = issue_valid & ~issue_kill & ~stall_int;
   end

   // Set/clear vectors; x0 never enters the mask, so a completion to x0 never clears.
   always_comb begin
      set_any  = accept & issue_long & (issue_rd != '0);
      clr_any  = complete_valid & pending_q[complete_rd];
      spurious = complete_valid & (complete_rd != '0) & ~pending_q[complete_rd];
      set_vec  = set_any ? reg_onehot(issue_rd)    : '0;
      clr_vec  = clr_any ? reg_onehot(complete_rd) : '0;
   end

   // Next-state for mask, occupancy and the sticky spurious-completion flag.
   always_comb begin
      pending_d      = (pending_q & ~clr_vec) | set_vec;
      outstanding_d  = outstanding_q;
      if (set_any && !clr_any) begin
         outstanding_d = outstanding_q + CNT_W'(1);
      end else if (clr_any && !set_any) begin
         outstanding_d = outstanding_q - CNT_W'(1);
      end
      err_spurious_d = err_spurious_q | spurious;
      if (reset) begin
         pending_d      = '0;
         outstanding_d  = '0;
         err_spurious_d = 1'b0;
      end
   end

   // State registers.
   always_ff @(posedge clk) begin
      pending_q      <= pending_d;
      outstanding_q  <= outstanding_d;
      err_spurious_q <= err_spurious_d;
   end

   sat_counter #(
      .W (XLEN)
   ) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (stall_int),
      .count (stall_cycles)
   );

   assign stall        = stall_int;
   assign pending      = pending_q;
   assign outstanding  = outstanding_q;
   assign full         = full_int & ~reset;
   assign err_spurious = err_spurious_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed-vector bench for hazard_scoreboard with hand-computed expectations.
// Latency: inputs applied after negedge, outputs checked 1 time unit later.
// Backpressure: stall observed combinationally each vector.
module tb_hazard_scoreboard;

   logic        clk;
   logic        reset;
   logic        issue_valid;
   logic [4:0]  issue_rs1;
   logic        issue_use_rs1;
   logic [4:0]  issue_rs2;
   logic        issue_use_rs2;
   logic [4:0]  issue_rd;
   logic        issue_long;
   logic        issue_kill;
   logic        complete_valid;
   logic [4:0]  complete_rd;
   logic        stall;
   logic [31:0] pending;
   logic [2:0]  outstanding;
   logic        full;
   logic        err_spurious;
   logic [31:0] stall_cycles;

   int n_vec;
   int n_err;

   hazard_scoreboard #(
      .MAX_OUTSTANDING (4),
      .CNT_W           (3)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .issue_valid    (issue_valid),
      .issue_rs1      (issue_rs1),
      .issue_use_rs1  (issue_use_rs1),
      .issue_rs2      (issue_rs2),
      .issue_use_rs2  (issue_use_rs2),
      .issue_rd       (issue_rd),
      .issue_long     (issue_long),
      .issue_kill     (issue_kill),
      .complete_valid (complete_valid),
      .complete_rd    (complete_rd),
      .stall          (stall),
      .pending        (pending),
      .outstanding    (outstanding),
      .full           (full),
      .err_spurious   (err_spurious),
      .stall_cycles   (stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its expectation.
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Apply one cycle of inputs and let combinational outputs settle.
   task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                        input logic lng, input logic kill, input logic cv, input logic [4:0] crd);
      issue_valid    = v;
      issue_rs1      = rs1;
      issue_use_rs1  = u1;
      issue_rs2      = rs2;
      issue_use_rs2  = u2;
      issue_rd       = rd;
      issue_long     = lng;
      issue_kill     = kill;
      complete_valid = cv;
      complete_rd    = crd;
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
   endtask

   task automatic issue_long_rd(input logic [4:0] rd);
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, rd, 1'b1, 1'b0, 1'b0, 5'd0);
   endtask

   task automatic complete(input logic [4:0] rd);
      drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, rd);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // A register must never be set and cleared in the same cycle.
   always @(negedge clk) begin
      #3;
      if (!reset && issue_valid && !issue_kill && !stall && issue_long && issue_rd != 5'd0 &&
          complete_valid && complete_rd == issue_rd && pending[issue_rd]) begin
         n_err++;
         $display("FAIL set_clr_same_rd: rd=%0d set and cleared together at %0t", issue_rd, $time);
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, vectors=%0d", n_vec);
      $fatal(1, "timeout");
   end

   initial begin
      n_vec = 0;
      n_err = 0;
      reset = 1'b1;
      idle();
      tick();
      tick();

      // Reset state; stall forced low even with a would-be hazard presented.
      drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 5'd0);
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_pending", pending, 32'd0);
      chk("rst_outstanding", {29'd0, outstanding}, 32'd0);
      chk("rst_full", {31'd0, full}, 32'd0);
      chk("rst_err", {31'd0, err_spurious}, 32'd0);
      chk("rst_stall_cycles", stall_cycles, 32'd0);
      tick();
      chk("rst_hold_pending", pending, 32'd0);
      reset = 1'b0;
      idle();
      tick();

      // Load-use: rd=5 issued, consumer stalls until completion in cycle 4.
      issue_long_rd(5'd5);
      chk("lu_issue_stall", {31'd0, stall}, 32'd0);
      tick();
      chk("lu_pending", pending, 32'h0000_0020);
      chk("lu_outstanding", {29'd0, outstanding}, 32'd1);
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd10, 1'b0, 1'b0, (i == 4), 5'd5);
         chk($sformatf("lu_stall_c%0d", i), {31'd0, stall}, 32'd1);
         tick();
      end
      drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd10, 1'b0, 1'b0, 1'b0, 5'd0);
      chk("lu_release", {31'd0, stall}, 32'd0);
      chk("lu_stall_cycles", stall_cycles, 32'd4);
      chk("lu_pending_clr", pending, 32'd0);
      tick();
      chk("lu_outstanding_end", {29'd0, outstanding}, 32'd0);

      // Same-cycle completion does not clear the RAW hazard.
      issue_long_rd(5'd7);
      tick();
      chk("sc_pending", pending, 32'h0000_0080);
      drive(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd11, 1'b0, 1'b0, 1'b1, 5'd7);
      chk("sc_stall", {31'd0, stall}, 32'd1);
      chk("sc_outstanding_1", {29'd0, outstanding}, 32'd1);
      tick();
      drive(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd11, 1'b0, 1'b0, 1'b0, 5'd0);
      chk("sc_release", {31'd0, stall}, 32'd0);
      chk("sc_outstanding_0", {29'd0, outstanding}, 32'd0);
      tick();

      // Capacity: four outstanding, fifth long op stalls until a slot frees.
      for (int r = 1; r <= 4; r++) begin
         issue_long_rd(5'(r));
         chk($sformatf("cap_issue_%0d", r), {31'd0, stall}, 32'd0);
         tick();
      end
      chk("cap_full", {31'd0, full}, 32'd1);
      chk("cap_outstanding", {29'd0, outstanding}, 32'd4);
      chk("cap_pending", pending, 32'h0000_001E);
      issue_long_rd(5'd6);
      chk("cap_stall_a", {31'd0, stall}, 32'd1);
      tick();
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b1, 5'd2);
      chk("cap_stall_b", {31'd0, stall}, 32'd1);
      tick();
      issue_long_rd(5'd6);
      chk("cap_accept", {31'd0, stall}, 32'd0);
      tick();
      chk("cap_outstanding_after", {29'd0, outstanding}, 32'd4);
      chk("cap_pending_after", pending, 32'h0000_005A);
      chk("cap_stall_cycles", stall_cycles, 32'd7);
      complete(5'd1); tick();
      complete(5'd3); tick();
      complete(5'd4); tick();
      complete(5'd6); tick();
      chk("cap_drained", pending, 32'd0);
      chk("cap_drained_cnt", {29'd0, outstanding}, 32'd0);
      chk("cap_not_full", {31'd0, full}, 32'd0);

      // x0: long op accepted without state change; completion to x0 ignored.
      issue_long_rd(5'd0);
      chk("x0_stall", {31'd0, stall}, 32'd0);
      tick();
      chk("x0_pending", pending, 32'd0);
      chk("x0_outstanding", {29'd0, outstanding}, 32'd0);
      complete(5'd0);
      tick();
      chk("x0_no_err", {31'd0, err_spurious}, 32'd0);

      // WAW: second long op to rd=9 waits for the first completion.
      issue_long_rd(5'd9);
      tick();
      issue_long_rd(5'd9);
      chk("waw_stall_a", {31'd0, stall}, 32'd1);
      tick();
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1, 5'd9);
      chk("waw_stall_b", {31'd0, stall}, 32'd1);
      tick();
      issue_long_rd(5'd9);
      chk("waw_accept", {31'd0, stall}, 32'd0);
      tick();
      chk("waw_pending", pending, 32'h0000_0200);
      chk("waw_outstanding", {29'd0, outstanding}, 32'd1);
      complete(5'd9);
      tick();

      // Kill: hazardous and long issues discarded with no stall and no state change.
      issue_long_rd(5'd11);
      tick();
      drive(1'b1, 5'd11, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b1, 1'b0, 5'd0);
      chk("kill_stall", {31'd0, stall}, 32'd0);
      tick();
      chk("kill_pending", pending, 32'h0000_0800);
      chk("kill_outstanding", {29'd0, outstanding}, 32'd1);
      complete(5'd11);
      tick();
      chk("kill_complete", pending, 32'd0);

      // Spurious completion is sticky.
      complete(5'd12);
      chk("spur_before", {31'd0, err_spurious}, 32'd0);
      tick();
      chk("spur_set", {31'd0, err_spurious}, 32'd1);
      chk("spur_no_state", {29'd0, outstanding}, 32'd0);
      idle();
      tick();
      chk("spur_sticky", {31'd0, err_spurious}, 32'd1);
      chk("stall_cycles_total", stall_cycles, 32'd9);

      // Reset mid-operation clears everything; a late completion then flags.
      issue_long_rd(5'd1); tick();
      issue_long_rd(5'd2); tick();
      chk("mid_pending", pending, 32'h0000_0006);
      reset = 1'b1;
      drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 5'd0);
      chk("mid_rst_stall", {31'd0, stall}, 32'd0);
      tick();
      reset = 1'b0;
      idle();
      chk("mid_pending_clr", pending, 32'd0);
      chk("mid_outstanding_clr", {29'd0, outstanding}, 32'd0);
      chk("mid_err_clr", {31'd0, err_spurious}, 32'd0);
      chk("mid_stall_cycles_clr", stall_cycles, 32'd0);
      complete(5'd1);
      tick();
      chk("mid_late_err", {31'd0, err_spurious}, 32'd1);
      chk("mid_late_pending", pending, 32'd0);
      idle();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
